// File: rtl/sccb_target.sv
// SCCB/I2C register target: decodes START/STOP, matches the device ID,
// turns writes into register strobes and shifts out bank data on reads.
module sccb_target #(
  parameter logic [7:0] DEVICE_ID   = 8'h42,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sioc,
  input  logic       siod_in,
  output logic       siod_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ID,
    S_ID_ACK,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_READ,
    S_MACK,
    S_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sc_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_sc_d;
  logic                   r_sd_d;

  state_t     r_state;
  logic [6:0] r_shift;
  logic [3:0] r_cnt;
  logic [7:0] r_ptr;
  logic       r_rw;
  logic       r_oe;
  logic       r_wr_en;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;

  logic       w_sc;
  logic       w_sd;
  logic       w_rise;
  logic       w_fall;
  logic       w_start;
  logic       w_stop;
  logic       w_take;
  logic       w_last;
  logic [7:0] w_byte;

  // Idle bus is high, so the synchronizers reset high to avoid false edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sc_sync <= '1;
      r_sd_sync <= '1;
      r_sc_d    <= 1'b1;
      r_sd_d    <= 1'b1;
    end else begin
      r_sc_sync <= {r_sc_sync[SYNC_STAGES-2:0], sioc};
      r_sd_sync <= {r_sd_sync[SYNC_STAGES-2:0], siod_in};
      r_sc_d    <= w_sc;
      r_sd_d    <= w_sd;
    end
  end

  assign w_sc    = r_sc_sync[SYNC_STAGES-1];
  assign w_sd    = r_sd_sync[SYNC_STAGES-1];
  assign w_rise  = w_sc & ~r_sc_d;
  assign w_fall  = ~w_sc & r_sc_d;
  assign w_start = w_sc & r_sc_d & r_sd_d & ~w_sd;
  assign w_stop  = w_sc & r_sc_d & ~r_sd_d & w_sd;
  assign w_take  = w_rise & ~r_cnt[3];
  assign w_last  = w_rise & (r_cnt == 4'd7);
  assign w_byte  = {r_shift, w_sd};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_rw      <= 1'b0;
      r_oe      <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_start) begin
        r_state <= S_ID;
        r_cnt   <= '0;
        r_oe    <= 1'b0;
      end else if (w_stop) begin
        r_state <= S_IDLE;
        r_oe    <= 1'b0;
      end else begin
        unique case (r_state)
          S_ID: begin
            if (w_take) begin
              r_shift <= w_byte[6:0];
              r_cnt   <= r_cnt + 4'd1;
            end
            if (w_last) begin
              r_rw <= w_sd;
              if (w_byte[7:1] != DEVICE_ID[7:1])
                r_state <= S_IGNORE;
            end
            if (w_fall && r_cnt[3]) begin
              r_oe    <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_ID_ACK;
            end
          end
          S_ID_ACK: begin
            if (w_fall) begin
              r_cnt <= '0;
              if (r_rw) begin
                r_state <= S_READ;
                r_shift <= rd_data[6:0];
                r_oe    <= ~rd_data[7];
              end else begin
                r_state <= S_ADDR;
                r_oe    <= 1'b0;
              end
            end
          end
          S_ADDR: begin
            if (w_take) begin
              r_shift <= w_byte[6:0];
              r_cnt   <= r_cnt + 4'd1;
            end
            if (w_last)
              r_ptr <= w_byte;
            if (w_fall && r_cnt[3]) begin
              r_oe    <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_ADDR_ACK;
            end
          end
          S_ADDR_ACK: begin
            if (w_fall) begin
              r_oe    <= 1'b0;
              r_state <= S_DATA;
            end
          end
          S_DATA: begin
            if (w_take) begin
              r_shift <= w_byte[6:0];
              r_cnt   <= r_cnt + 4'd1;
            end
            if (w_last) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_ptr;
              r_wr_data <= w_byte;
            end
            if (w_fall && r_cnt[3]) begin
              r_oe    <= 1'b1;
              r_cnt   <= '0;
              r_state <= S_DATA_ACK;
            end
          end
          S_DATA_ACK: begin
            if (w_fall) begin
              r_oe    <= 1'b0;
              r_ptr   <= r_ptr + 8'd1;
              r_state <= S_DATA;
            end
          end
          S_READ: begin
            if (w_rise)
              r_cnt <= r_cnt + 4'd1;
            if (w_fall) begin
              if (r_cnt[3]) begin
                r_oe    <= 1'b0;
                r_cnt   <= '0;
                r_state <= S_MACK;
              end else begin
                r_oe    <= ~r_shift[6];
                r_shift <= {r_shift[5:0], 1'b0};
              end
            end
          end
          S_MACK: begin
            // Pointer moves on the master-ACK sample so rd_data settles
            // well before the next byte is loaded on the falling edge.
            if (w_rise) begin
              if (w_sd)
                r_state <= S_IGNORE;
              else
                r_ptr <= r_ptr + 8'd1;
            end
            if (w_fall) begin
              r_state <= S_READ;
              r_cnt   <= '0;
              r_shift <= rd_data[6:0];
              r_oe    <= ~rd_data[7];
            end
          end
          S_IDLE, S_IGNORE: begin
            r_oe <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_oe    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign siod_oe = r_oe;
  assign wr_en   = r_wr_en;
  assign wr_addr = r_wr_addr;
  assign wr_data = r_wr_data;
  assign rd_addr = r_ptr;
  assign busy    = (r_state != S_IDLE) && (r_state != S_IGNORE);

endmodule
